btn_debounce_peri: RTL and testbench

Memory-mapped push-button peripheral sitting on the CPU peripheral bus alongside the timer. It synchronizes and debounces up to N_BTN raw button pins, latches press events in a write-1-to-clear register, and raises a maskable level interrupt. Software polls it through the same wen/addr/wdata/rdata bus used by every other peripheral. It is the input-side counterpart feeding the CPU's polling and timing loops.

---
 rtl/btn_debounce_peri_pkg.sv | 28 ++
 rtl/btn_debounce_ch.sv | 48 ++++
 rtl/btn_debounce_peri.sv | 71 +++++++
 tb/tb_btn_debounce_peri.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/btn_debounce_peri_pkg.sv
// Shared register map and address decode for the push-button peripheral.
// The addresses match the PERI_ADDR_* values used by the rest of the peripheral bus.
package btn_debounce_peri_pkg;

    localparam logic [31:0] PERI_ADDR_BTN     = 32'hFFFF_F078;
    localparam logic [31:0] PERI_ADDR_BTN_EVT = 32'hFFFF_F07C;
    localparam logic [31:0] PERI_ADDR_BTN_MSK = 32'hFFFF_F080;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_BTN,
        REG_EVT,
        REG_MSK
    } reg_sel_e;

    function automatic reg_sel_e decode_addr(input logic [31:0] addr);
        reg_sel_e sel;
        sel = REG_NONE;
        case (addr)
            PERI_ADDR_BTN:     sel = REG_BTN;
            PERI_ADDR_BTN_EVT: sel = REG_EVT;
            PERI_ADDR_BTN_MSK: sel = REG_MSK;
            default:           sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchronizer followed by a stable-count debouncer.
// level is the debounced value; rise_pulse marks the edge where level goes 0->1.
module btn_debounce_ch #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise_pulse
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_ff;
    logic          sync;
    logic          stable;
    logic [CW-1:0] cnt;
    logic          accept;

    assign sync   = sync_ff[1];
    assign accept = (sync != stable) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= 2'b00;
            stable  <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_ff <= {sync_ff[0], din};
            if (sync == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // High in the cycle whose closing edge raises level, so the event
    // register in the parent updates on that same edge.
    assign rise_pulse = accept && sync;
    assign level      = stable;

endmodule

// File: rtl/btn_debounce_peri.sv
// Push-button peripheral: debounced levels, W1C press events, interrupt mask,
// registered level irq and a 1-cycle-latency read port on the peripheral bus.
module btn_debounce_peri
    import btn_debounce_peri_pkg::*;
#(
    parameter int N_BTN      = 5,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [31:0]      wdata,
    input  logic [31:0]      addr,
    output logic [31:0]      rdata,
    input  logic [N_BTN-1:0] button,
    output logic             irq
);

    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] evt;
    logic [N_BTN-1:0] mask;
    logic [N_BTN-1:0] evt_clr;
    logic             mask_we;
    logic [31:0]      rd_next;
    reg_sel_e         sel;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .din       (button[i]),
            .level     (level[i]),
            .rise_pulse(rise[i])
        );
    end

    assign sel     = decode_addr(addr);
    assign mask_we = wen && (sel == REG_MSK);
    assign evt_clr = (wen && (sel == REG_EVT)) ? wdata[N_BTN-1:0] : '0;

    always_comb begin
        rd_next = 32'h0;
        case (sel)
            REG_BTN: rd_next = 32'(level);
            REG_EVT: rd_next = 32'(evt);
            REG_MSK: rd_next = 32'(mask);
            default: rd_next = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt   <= '0;
            mask  <= '0;
            irq   <= 1'b0;
            rdata <= 32'h0;
        end else begin
            // A new press outranks a same-cycle clear of that bit.
            evt <= (evt & ~evt_clr) | rise;
            if (mask_we) begin
                mask <= wdata[N_BTN-1:0];
            end
            irq   <= |(evt & mask);
            rdata <= rd_next;
        end
    end

endmodule

// File: tb/tb_btn_debounce_peri.sv
// Directed bench for btn_debounce_peri with DEB_CYCLES=4, N_BTN=5.
module tb_btn_debounce_peri;

    localparam int N_BTN      = 5;
    localparam int DEB_CYCLES = 4;

    localparam logic [31:0] A_BTN  = 32'hFFFF_F078;
    localparam logic [31:0] A_EVT  = 32'hFFFF_F07C;
    localparam logic [31:0] A_MSK  = 32'hFFFF_F080;
    localparam logic [31:0] A_NONE = 32'hFFFF_F000;

    logic             clk;
    logic             rst;
    logic             wen;
    logic [31:0]      wdata;
    logic [31:0]      addr;
    logic [31:0]      rdata;
    logic [N_BTN-1:0] button;
    logic             irq;

    int checks;
    int errors;
    logic [31:0] exp_q[$];

    btn_debounce_peri #(
        .N_BTN     (N_BTN),
        .DEB_CYCLES(DEB_CYCLES)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .wen   (wen),
        .wdata (wdata),
        .addr  (addr),
        .rdata (rdata),
        .button(button),
        .irq   (irq)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        wen   = 1'b1;
        addr  = a;
        wdata = d;
        tick(1);
        wen   = 1'b0;
        wdata = 32'h0;
        addr  = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
        addr = a;
        exp_q.push_back(exp);
        tick(1);
        check(tag, rdata, exp_q.pop_front());
    endtask

    logic [7:0] bounce_seq;

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        wen        = 1'b0;
        wdata      = 32'h0;
        addr       = 32'h0;
        button     = '0;
        bounce_seq = 8'b1111_0111;  // bit j is the value driven in cycle j
        tick(2);
        check("rst_rdata", rdata, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        rst = 1'b0;
        bus_read(A_BTN, 32'h0, "idle_btn");

        // clean press: level rises on the 6th edge, evt on that same edge
        addr   = A_BTN;
        button = 5'b00001;
        tick(6);
        check("press_btn_before", rdata, 32'h0);
        addr = A_EVT;
        tick(1);
        check("press_evt_same_edge", rdata, 32'h1);
        addr = A_BTN;
        tick(1);
        check("press_btn_after", rdata, 32'h1);
        check("press_irq_masked", {31'h0, irq}, 32'h0);

        // bounce on channel 1: glitch in cycle 3 delays the rise to edge 10
        addr = A_BTN;
        for (int j = 0; j < 8; j++) begin
            button[1] = bounce_seq[j];
            tick(1);
            if (j == 6) check("bounce_not_yet", rdata, 32'h1);
        end
        tick(3);
        check("bounce_btn", rdata, 32'h3);
        bus_read(A_EVT, 32'h3, "bounce_evt");

        // W1C
        bus_write(A_EVT, 32'h1);
        bus_read(A_EVT, 32'h2, "w1c_bit0");
        bus_write(A_EVT, 32'h2);
        bus_read(A_EVT, 32'h0, "w1c_bit1");
        tick(8);
        bus_read(A_EVT, 32'h0, "bounce_no_second_evt");

        // set/clear collision on bit 2: clear lands on the rising edge
        button[2] = 1'b1;
        tick(5);
        bus_write(A_EVT, 32'h4);
        bus_read(A_EVT, 32'h4, "collision_set_wins");
        check("collision_irq_masked", {31'h0, irq}, 32'h0);

        // interrupt masking
        bus_write(A_MSK, 32'hFFFF_FFFF);
        check("irq_at_mask_edge", {31'h0, irq}, 32'h0);
        tick(1);
        check("irq_after_mask", {31'h0, irq}, 32'h1);
        bus_read(A_MSK, 32'h1F, "msk_readback");
        bus_write(A_EVT, 32'h4);
        check("irq_at_clear_edge", {31'h0, irq}, 32'h1);
        tick(1);
        check("irq_after_clear", {31'h0, irq}, 32'h0);

        // reads and ignored writes
        bus_read(A_NONE, 32'h0, "unmapped_read");
        bus_write(A_BTN, 32'hFFFF_FFFF);
        bus_read(A_BTN, 32'h7, "btn_write_ignored");
        bus_read(A_EVT, 32'h0, "evt_after_clear");
        bus_write(32'hFFFF_F084, 32'h0);
        bus_read(A_MSK, 32'h1F, "unmapped_write_ignored");

        // reset two cycles into a count on channel 3
        addr      = A_BTN;
        button[3] = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(1);
        check("midrst_rdata", rdata, 32'h0);
        check("midrst_irq", {31'h0, irq}, 32'h0);
        rst = 1'b0;
        tick(6);
        check("postrst_btn_before", rdata, 32'h0);
        addr = A_EVT;
        tick(1);
        check("postrst_evt", rdata, 32'hF);
        check("postrst_irq", {31'h0, irq}, 32'h0);
        bus_read(A_MSK, 32'h0, "postrst_msk");
        bus_read(A_BTN, 32'hF, "postrst_btn");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
